// File: rtl/mem_resp_pkg.sv
// Shared types and default parameters for the mem_responder bus slave.
package mem_resp_pkg;

  localparam int DATA_W_DEF      = 32;
  localparam int DEPTH_DEF       = 16;
  localparam int WAIT_CYCLES_DEF = 2;
  localparam int ADDR_W          = 5;
  localparam int CNT_W           = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2,
    ST_ERR  = 2'd3
  } resp_state_e;

endpackage

// File: rtl/resp_wait_cnt.sv
// Wait-state down-counter: load on WAIT entry, decrement per cycle, flag zero.
module resp_wait_cnt
  import mem_resp_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // NOTE: combinational blocks assign a default first so no path holds a value
  // (no latch); sequential blocks use <= so every flop samples pre-edge values.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/mem_responder.sv
// Wait-stated four-phase memory slave with a small register-file memory.
// Define MEM_RESP_ERR_EN to add the err_n port and the ERR state for addr >= DEPTH.
module mem_responder
  import mem_resp_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int DEPTH       = DEPTH_DEF,
  parameter int WAIT_CYCLES = WAIT_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              as_n,
  input  logic              wr_n,
  input  logic [4:0]        addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              ack_n,
  output logic [DATA_W-1:0] rdata,
  output logic [1:0]        resp_state
`ifdef MEM_RESP_ERR_EN
  ,
  output logic              err_n
`endif
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;

  resp_state_e       state_q, state_d;
  logic [4:0]        addr_q, addr_d;
  logic              wr_n_q, wr_n_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              ack_n_q, ack_n_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];

  logic              cnt_load, cnt_dec, cnt_zero;
  logic              commit, go_err;
  logic [4:0]        acc_addr;
  logic              acc_wr_n;
  logic [DATA_W-1:0] acc_wdata;
  logic [AW-1:0]     idx;

  resp_wait_cnt u_wait_cnt (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (cnt_load),
    .load_val (CNT_INIT),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  // With no wait states the access commits on the accept edge, before the latch holds it.
  assign acc_addr  = (state_q == ST_IDLE) ? addr  : addr_q;
  assign acc_wr_n  = (state_q == ST_IDLE) ? wr_n  : wr_n_q;
  assign acc_wdata = (state_q == ST_IDLE) ? wdata : wdata_q;
  assign idx       = AW'({1'b0, acc_addr} % 6'(DEPTH));

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wr_n_d   = wr_n_q;
    wdata_d  = wdata_q;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    commit   = 1'b0;
    go_err   = 1'b0;
`ifdef MEM_RESP_ERR_EN
    go_err   = ({1'b0, acc_addr} >= 6'(DEPTH));
`endif
    case (state_q)
      ST_IDLE: begin
        if (!as_n) begin
          addr_d  = addr;
          wr_n_d  = wr_n;
          wdata_d = wdata;
          if (WAIT_CYCLES > 0) begin
            state_d  = ST_WAIT;
            cnt_load = 1'b1;
          end else begin
            state_d = go_err ? ST_ERR : ST_ACK;
            commit  = !go_err;
          end
        end
      end
      ST_WAIT: begin
        // Abort wins over the transition into ACK on the same edge.
        if (as_n) begin
          state_d = ST_IDLE;
        end else if (cnt_zero) begin
          state_d = go_err ? ST_ERR : ST_ACK;
          commit  = !go_err;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_ACK, ST_ERR: begin
        if (as_n) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    mem_d   = mem_q;
    rdata_d = rdata_q;
    if (commit) begin
      if (acc_wr_n) begin
        rdata_d = mem_q[idx];
      end else begin
        mem_d[idx] = acc_wdata;
      end
    end
    // ack_n trails the state by one edge, giving the k+1+WAIT_CYCLES fall time.
    ack_n_d = (state_q != ST_ACK);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      wr_n_q  <= 1'b1;
      wdata_q <= '0;
      ack_n_q <= 1'b1;
      rdata_q <= '0;
      // NOTE: the memory is cleared by reset, so it is built from resettable flops
      // rather than a RAM macro; the loop unrolls to one clear per word.
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wr_n_q  <= wr_n_d;
      wdata_q <= wdata_d;
      ack_n_q <= ack_n_d;
      rdata_q <= rdata_d;
      mem_q   <= mem_d;
    end
  end

`ifdef MEM_RESP_ERR_EN
  logic err_n_q, err_n_d;

  assign err_n_d = (state_d != ST_ERR);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      err_n_q <= 1'b1;
    end else begin
      err_n_q <= err_n_d;
    end
  end

  assign err_n = err_n_q;
`endif

  assign ack_n      = ack_n_q;
  assign rdata      = rdata_q;
  assign resp_state = state_q;

endmodule
